// File: rtl/ic_irq_sequencer.sv
// Interrupt sequencer: edge-captures 8 request lines into a masked pending
// register and offers one vector at a time to the CPU over valid/ready.
// Ports: clk, rstn (async low); irq_in[7:0] request levels;
//   cfg_we/cfg_addr/cfg_wdata/cfg_rdata register port
//   (0 MASK, 1 CTRL, 2 PENDING, 3 STATUS);
//   irq_valid/irq_vec/irq_ready vector offer; eoi end-of-interrupt;
//   in_service while servicing; timeout_irq one-cycle watchdog pulse.
module ic_irq_sequencer #(
    parameter int NUM_IRQ        = 8,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic [NUM_IRQ-1:0] irq_in,
    input  logic               cfg_we,
    input  logic [1:0]         cfg_addr,
    input  logic [7:0]         cfg_wdata,
    output logic [7:0]         cfg_rdata,
    output logic               irq_valid,
    output logic [2:0]         irq_vec,
    input  logic               irq_ready,
    input  logic               eoi,
    output logic               in_service,
    output logic               timeout_irq
);

    localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        OFFER   = 2'd1,
        SERVICE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [NUM_IRQ-1:0] irq_q;
    logic [NUM_IRQ-1:0] pend_q, pend_d;
    logic [NUM_IRQ-1:0] mask_q, mask_d;
    logic [1:0]         ctrl_q, ctrl_d;
    logic [2:0]         last_q, last_d;
    logic               stky_q, stky_d;
    logic [2:0]         vec_q, vec_d;
    logic [WDW-1:0]     wd_q, wd_d;

    logic [NUM_IRQ-1:0] rise;
    logic [NUM_IRQ-1:0] sw_clr;
    logic [NUM_IRQ-1:0] hs_clr;
    logic               fire;
    logic [2:0]         sel_id;
    logic [2:0]         start;
    logic [2:0]         idx;
    logic               found;
    logic               wr_mask, wr_ctrl, wr_pend, wr_stat;

    assign wr_mask = cfg_we && (cfg_addr == 2'd0);
    assign wr_ctrl = cfg_we && (cfg_addr == 2'd1);
    assign wr_pend = cfg_we && (cfg_addr == 2'd2);
    assign wr_stat = cfg_we && (cfg_addr == 2'd3);

    // Masked edges are dropped here, never deferred.
    assign rise   = irq_in & ~irq_q & mask_q;
    assign sw_clr = wr_pend ? cfg_wdata : '0;

    // Wrapping search; fixed mode always starts at 0.
    always_comb begin
        start  = ctrl_q[0] ? last_q + 3'd1 : 3'd0;
        sel_id = '0;
        idx    = '0;
        found  = 1'b0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            idx = start + 3'(i);
            if (!found && pend_q[idx]) begin
                sel_id = idx;
                found  = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        last_d  = last_q;
        wd_d    = wd_q;
        hs_clr  = '0;
        fire    = 1'b0;
        unique case (state_q)
            IDLE: begin
                wd_d = '0;
                if (ctrl_q[1] && (pend_q != '0)) begin
                    vec_d   = sel_id;
                    state_d = OFFER;
                end
            end
            OFFER: begin
                if (irq_ready) begin
                    hs_clr[vec_q] = 1'b1;
                    last_d        = vec_q;
                    wd_d          = '0;
                    state_d       = SERVICE;
                end
            end
            SERVICE: begin
                // eoi on the final cycle beats the watchdog.
                if (eoi) begin
                    wd_d    = '0;
                    state_d = IDLE;
                end else if (wd_q == WD_LAST) begin
                    fire    = 1'b1;
                    wd_d    = '0;
                    state_d = IDLE;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // New edges win over any clear of the same bit.
    assign pend_d = (pend_q & ~(sw_clr | hs_clr)) | rise;
    assign mask_d = wr_mask ? cfg_wdata : mask_q;
    assign ctrl_d = wr_ctrl ? cfg_wdata[1:0] : ctrl_q;
    assign stky_d = (stky_q & ~(wr_stat & cfg_wdata[3])) | fire;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            irq_q   <= '0;
            pend_q  <= '0;
            mask_q  <= '1;
            ctrl_q  <= 2'b10;
            last_q  <= 3'd7;
            stky_q  <= 1'b0;
            vec_q   <= '0;
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            irq_q   <= irq_in;
            pend_q  <= pend_d;
            mask_q  <= mask_d;
            ctrl_q  <= ctrl_d;
            last_q  <= last_d;
            stky_q  <= stky_d;
            vec_q   <= vec_d;
            wd_q    <= wd_d;
        end
    end

    assign irq_valid   = (state_q == OFFER);
    assign in_service  = (state_q == SERVICE);
    assign irq_vec     = vec_q;
    assign timeout_irq = fire;

    always_comb begin
        cfg_rdata = '0;
        unique case (cfg_addr)
            2'd0: cfg_rdata = mask_q;
            2'd1: cfg_rdata = {6'b0, ctrl_q};
            2'd2: cfg_rdata = pend_q;
            2'd3: cfg_rdata = {2'b0, irq_valid, in_service,
                               stky_q, last_q};
            default: cfg_rdata = '0;
        endcase
    end

endmodule

// File: tb/tb_ic_irq_sequencer.sv
// Directed plus randomized bench for ic_irq_sequencer.
// Random rounds are checked against a service-order list model.
module tb_ic_irq_sequencer;

    logic       clk = 1'b0;
    logic       rstn;
    logic [7:0] irq_in;
    logic       cfg_we;
    logic [1:0] cfg_addr;
    logic [7:0] cfg_wdata;
    logic [7:0] cfg_rdata;
    logic       irq_valid;
    logic [2:0] irq_vec;
    logic       irq_ready;
    logic       eoi;
    logic       in_service;
    logic       timeout_irq;

    int n_cmp = 0;
    int n_err = 0;

    ic_irq_sequencer #(
        .NUM_IRQ(8),
        .TIMEOUT_CYCLES(64)
    ) dut (
        .clk(clk),
        .rstn(rstn),
        .irq_in(irq_in),
        .cfg_we(cfg_we),
        .cfg_addr(cfg_addr),
        .cfg_wdata(cfg_wdata),
        .cfg_rdata(cfg_rdata),
        .irq_valid(irq_valid),
        .irq_vec(irq_vec),
        .irq_ready(irq_ready),
        .eoi(eoi),
        .in_service(in_service),
        .timeout_irq(timeout_irq)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic rd(input logic [1:0] a, input logic [7:0] exp,
                      input string tag);
        cfg_addr = a;
        #1;
        chk(tag, cfg_rdata, exp);
    endtask

    task automatic wr(input logic [1:0] a, input logic [7:0] d);
        cfg_we    = 1'b1;
        cfg_addr  = a;
        cfg_wdata = d;
        tick();
        cfg_we    = 1'b0;
    endtask

    task automatic pulse(input logic [7:0] v);
        irq_in = v;
        tick();
        irq_in = 8'h00;
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (!irq_valid && n < 12) begin
            tick();
            n++;
        end
        chk({tag, "_valid"}, 8'(irq_valid), 8'h01);
    endtask

    task automatic serve(input logic [2:0] id, input string tag);
        wait_valid(tag);
        chk({tag, "_vec"}, 8'(irq_vec), 8'(id));
        irq_ready = 1'b1;
        tick();
        irq_ready = 1'b0;
        chk({tag, "_insvc"}, 8'(in_service), 8'h01);
        eoi = 1'b1;
        tick();
        eoi = 1'b0;
        chk({tag, "_idle"}, 8'(in_service), 8'h00);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        logic [2:0] q[$];
        logic [2:0] mlast;
        logic [2:0] st;
        logic [2:0] id;
        logic [7:0] mask;
        logic [7:0] lines;
        logic [7:0] set;
        logic       mode;
        int         early;

        rstn      = 1'b0;
        irq_in    = 8'h00;
        cfg_we    = 1'b0;
        cfg_addr  = 2'd0;
        cfg_wdata = 8'h00;
        irq_ready = 1'b0;
        eoi       = 1'b0;
        tick();
        tick();
        rstn = 1'b1;
        tick();

        // Reset state
        chk("rst_valid", 8'(irq_valid), 8'h00);
        chk("rst_vec", 8'(irq_vec), 8'h00);
        chk("rst_insvc", 8'(in_service), 8'h00);
        chk("rst_tmo", 8'(timeout_irq), 8'h00);
        rd(2'd0, 8'hFF, "rst_mask");
        rd(2'd1, 8'h02, "rst_ctrl");
        tick();
        rd(2'd2, 8'h00, "rst_pend");
        rd(2'd3, 8'h07, "rst_stat");

        // 1: single request, two-cycle latency
        tick();
        irq_in = 8'h01;
        tick();
        chk("t1_valid_early", 8'(irq_valid), 8'h00);
        rd(2'd2, 8'h01, "t1_pend_set");
        tick();
        chk("t1_valid", 8'(irq_valid), 8'h01);
        chk("t1_vec", 8'(irq_vec), 8'h00);
        irq_ready = 1'b1;
        tick();
        irq_ready = 1'b0;
        chk("t1_insvc", 8'(in_service), 8'h01);
        rd(2'd2, 8'h00, "t1_pend_clr");
        eoi = 1'b1;
        tick();
        eoi = 1'b0;
        chk("t1_idle", 8'(in_service), 8'h00);
        chk("t1_novalid", 8'(irq_valid), 8'h00);
        irq_in = 8'h00;
        tick();

        // 2: fixed priority, held level does not re-pend
        irq_in = 8'h90;
        tick();
        tick();
        serve(3'd4, "t2_a");
        serve(3'd7, "t2_b");
        tick();
        tick();
        tick();
        chk("t2_norepend", 8'(irq_valid), 8'h00);
        rd(2'd2, 8'h00, "t2_pend");
        irq_in = 8'h00;
        tick();

        // 3: round robin
        wr(2'd1, 8'h03);
        pulse(8'hFF);
        serve(3'd0, "t3_0");
        serve(3'd1, "t3_1");
        serve(3'd2, "t3_2");
        serve(3'd3, "t3_3");
        pulse(8'h03);
        serve(3'd4, "t3_4");
        serve(3'd5, "t3_5");
        serve(3'd6, "t3_6");
        serve(3'd7, "t3_7");
        serve(3'd0, "t3_0b");
        serve(3'd1, "t3_1b");
        rd(2'd2, 8'h00, "t3_pend");

        // 4: mask drops edges; unmask under held level is silent
        wr(2'd1, 8'h02);
        wr(2'd0, 8'hFE);
        irq_in = 8'h01;
        tick();
        tick();
        chk("t4_masked_valid", 8'(irq_valid), 8'h00);
        rd(2'd2, 8'h00, "t4_masked_pend");
        wr(2'd0, 8'hFF);
        tick();
        tick();
        chk("t4_unmask_valid", 8'(irq_valid), 8'h00);
        rd(2'd2, 8'h00, "t4_unmask_pend");
        irq_in = 8'h00;
        tick();

        // 5: watchdog timeout after 64 service cycles
        pulse(8'h04);
        wait_valid("t5a");
        chk("t5a_vec", 8'(irq_vec), 8'h02);
        irq_ready = 1'b1;
        tick();
        irq_ready = 1'b0;
        early = 0;
        for (int i = 0; i < 63; i++) begin
            if (timeout_irq || !in_service) early++;
            tick();
        end
        chk("t5a_early", 8'(early), 8'h00);
        chk("t5a_insvc", 8'(in_service), 8'h01);
        chk("t5a_tmo", 8'(timeout_irq), 8'h01);
        tick();
        chk("t5a_tmo_off", 8'(timeout_irq), 8'h00);
        chk("t5a_idle", 8'(in_service), 8'h00);
        rd(2'd3, 8'h0A, "t5a_stat");
        wr(2'd3, 8'h08);
        rd(2'd3, 8'h02, "t5a_w1c");
        pulse(8'h04);
        wait_valid("t5b");
        irq_ready = 1'b1;
        tick();
        irq_ready = 1'b0;
        for (int i = 0; i < 63; i++) tick();
        eoi = 1'b1;
        #1;
        chk("t5b_tmo", 8'(timeout_irq), 8'h00);
        tick();
        eoi = 1'b0;
        chk("t5b_idle", 8'(in_service), 8'h00);
        rd(2'd3, 8'h02, "t5b_stat");

        // 6: offer holds vector through config changes; reset mid-service
        pulse(8'h08);
        wait_valid("t6");
        chk("t6_vec", 8'(irq_vec), 8'h03);
        wr(2'd1, 8'h00);
        wr(2'd2, 8'h08);
        chk("t6_hold_valid", 8'(irq_valid), 8'h01);
        chk("t6_hold_vec", 8'(irq_vec), 8'h03);
        rd(2'd2, 8'h00, "t6_pend_w1c");
        pulse(8'h02);
        chk("t6_hold_vec2", 8'(irq_vec), 8'h03);
        rd(2'd2, 8'h02, "t6_pend_new");
        irq_ready = 1'b1;
        tick();
        irq_ready = 1'b0;
        chk("t6_insvc", 8'(in_service), 8'h01);
        rd(2'd3, 8'h13, "t6_stat");
        tick();
        rstn = 1'b0;
        #1;
        chk("t6_rst_valid", 8'(irq_valid), 8'h00);
        chk("t6_rst_vec", 8'(irq_vec), 8'h00);
        chk("t6_rst_insvc", 8'(in_service), 8'h00);
        chk("t6_rst_tmo", 8'(timeout_irq), 8'h00);
        rd(2'd0, 8'hFF, "t6_rst_mask");
        rd(2'd1, 8'h02, "t6_rst_ctrl");
        tick();
        rd(2'd2, 8'h00, "t6_rst_pend");
        rd(2'd3, 8'h07, "t6_rst_stat");
        tick();
        rstn = 1'b1;
        tick();

        // Randomized batches against a service-order model
        mlast = 3'd7;
        for (int r = 0; r < 10; r++) begin
            mode  = 1'($urandom_range(0, 1));
            mask  = 8'($urandom_range(0, 255));
            lines = 8'($urandom_range(1, 255));
            wr(2'd1, {6'b0, 1'b1, mode});
            wr(2'd0, mask);
            set = lines & mask;
            st  = mode ? 3'(mlast + 3'd1) : 3'd0;
            q.delete();
            for (int k = 0; k < 8; k++) begin
                id = 3'((int'(st) + k) % 8);
                if (set[id]) q.push_back(id);
            end
            pulse(lines);
            if (q.size() == 0) begin
                tick();
                tick();
                chk("rnd_empty_valid", 8'(irq_valid), 8'h00);
            end
            foreach (q[j]) begin
                serve(q[j], $sformatf("rnd%0d_%0d", r, j));
                mlast = q[j];
            end
            rd(2'd2, 8'h00, "rnd_pend");
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
